// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state/coin types, coin unit constants and helpers for vend_sequencer
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CREDIT    = 3'd1,
        VEND_REQ  = 3'd2,
        VEND_WAIT = 3'd3,
        CHG_SEL   = 3'd4,
        CHG_PULSE = 3'd5,
        CHG_GAP   = 3'd6
    } vend_state_t;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'd0,
        COIN_DIME    = 2'd1,
        COIN_QUARTER = 2'd2,
        COIN_HALF    = 2'd3
    } coin_code_t;

    localparam logic [6:0] NICKEL_U  = 7'd1;
    localparam logic [6:0] DIME_U    = 7'd2;
    localparam logic [6:0] QUARTER_U = 7'd5;
    localparam logic [6:0] HALF_U    = 7'd10;

    function automatic logic [6:0] coin_value(input coin_code_t code);
        logic [6:0] units;
        units = NICKEL_U;
        case (code)
            COIN_NICKEL:  units = NICKEL_U;
            COIN_DIME:    units = DIME_U;
            COIN_QUARTER: units = QUARTER_U;
            COIN_HALF:    units = HALF_U;
            default:      units = NICKEL_U;
        endcase
        return units;
    endfunction

    // Greedy change: largest releasable coin not exceeding what is still owed.
    function automatic logic [6:0] change_unit(input logic [6:0] amount);
        if (amount >= QUARTER_U)
            return QUARTER_U;
        else if (amount >= DIME_U)
            return DIME_U;
        else
            return NICKEL_U;
    endfunction

endpackage

// File: rtl/vend_pulse_timer.sv
// rtl/vend_pulse_timer.sv - loadable down-counter with a done flag, shared for pulse/gap/ack timing
module vend_pulse_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - WIDTH'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending transaction controller: credit, dispense handshake, change payout
// Optional: define VEND_ACK_TIMEOUT_EN to abort a stalled dispense after ACK_TIMEOUT cycles and refund.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE_UNITS  = 5,
    parameter int PULSE_CYCLES = 16,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic       CLK50M,
    input  logic       RSTb,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       cancel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic       coin_rej,
    output logic       chg_q,
    output logic       chg_d,
    output logic       chg_n,
    output logic [6:0] credit,
    output logic [2:0] state,
    output logic       fault
);

    localparam int TMR_MAX = (ACK_TIMEOUT > PULSE_CYCLES) ? ACK_TIMEOUT : PULSE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [6:0]       PRICE      = 7'(PRICE_UNITS);
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
`ifdef VEND_ACK_TIMEOUT_EN
    localparam logic [TMR_W-1:0] ACK_LOAD   = TMR_W'(ACK_TIMEOUT - 1);
`endif

    vend_state_t      cur_state, nxt_state;
    logic [6:0]       credit_q, credit_nxt;
    logic [6:0]       coin_sum, cur_unit, pay_unit;
    logic             tmr_load, tmr_done, timeout;
    logic [TMR_W-1:0] tmr_val;
    logic             disp_req_nxt, coin_rej_nxt, chg_q_nxt, chg_d_nxt, chg_n_nxt, fault_nxt;

    assign coin_sum = credit_q + coin_value(coin_code_t'(coin_code));
    assign cur_unit = change_unit(credit_q);
    assign credit   = credit_q;
    assign state    = cur_state;

    vend_pulse_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (CLK50M),
        .rst_n    (RSTb),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            cur_state <= IDLE;
            credit_q  <= '0;
            disp_req  <= 1'b0;
            coin_rej  <= 1'b0;
            chg_q     <= 1'b0;
            chg_d     <= 1'b0;
            chg_n     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            credit_q  <= credit_nxt;
            disp_req  <= disp_req_nxt;
            coin_rej  <= coin_rej_nxt;
            chg_q     <= chg_q_nxt;
            chg_d     <= chg_d_nxt;
            chg_n     <= chg_n_nxt;
            fault     <= fault_nxt;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        credit_nxt = credit_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        timeout    = 1'b0;
        case (cur_state)
            IDLE, CREDIT: begin
                // cancel beats a simultaneous coin; with nothing credited it does nothing
                if (cancel) begin
                    if (cur_state == CREDIT)
                        nxt_state = CHG_SEL;
                end else if (coin_valid) begin
                    credit_nxt = coin_sum;
                    if (coin_sum >= PRICE) begin
                        nxt_state = VEND_REQ;
`ifdef VEND_ACK_TIMEOUT_EN
                        tmr_load  = 1'b1;
                        tmr_val   = ACK_LOAD;
`endif
                    end else begin
                        nxt_state = CREDIT;
                    end
                end
            end
            VEND_REQ: nxt_state = VEND_WAIT;
            VEND_WAIT: begin
                if (disp_ack) begin
                    credit_nxt = credit_q - PRICE;
                    nxt_state  = (credit_q != PRICE) ? CHG_SEL : IDLE;
                end
`ifdef VEND_ACK_TIMEOUT_EN
                else if (tmr_done) begin
                    timeout   = 1'b1;
                    nxt_state = CHG_SEL;
                end
`endif
            end
            CHG_SEL: begin
                nxt_state = CHG_PULSE;
                tmr_load  = 1'b1;
                tmr_val   = PULSE_LOAD;
            end
            CHG_PULSE: begin
                if (tmr_done) begin
                    credit_nxt = credit_q - cur_unit;
                    nxt_state  = CHG_GAP;
                    tmr_load   = 1'b1;
                    tmr_val    = PULSE_LOAD;
                end
            end
            CHG_GAP: begin
                if (tmr_done)
                    nxt_state = (credit_q != '0) ? CHG_SEL : IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state; credit is stable for the whole pulse.
    always_comb begin
        pay_unit     = change_unit(credit_nxt);
        disp_req_nxt = (nxt_state == VEND_REQ) || (nxt_state == VEND_WAIT);
        coin_rej_nxt = coin_valid && (cancel || !((cur_state == IDLE) || (cur_state == CREDIT)));
        chg_q_nxt    = (nxt_state == CHG_PULSE) && (pay_unit == QUARTER_U);
        chg_d_nxt    = (nxt_state == CHG_PULSE) && (pay_unit == DIME_U);
        chg_n_nxt    = (nxt_state == CHG_PULSE) && (pay_unit == NICKEL_U);
        fault_nxt    = timeout;
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed and randomized bench for vend_sequencer against a payout-timeline model
module tb_vend_sequencer;

    localparam int PR  = 5;
    localparam int P   = 16;
    localparam int AT  = 8;
    localparam int PER = 2 * P + 1;

    logic       CLK50M     = 1'b0;
    logic       RSTb       = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code  = 2'd0;
    logic       cancel     = 1'b0;
    logic       disp_ack   = 1'b0;
    logic       disp_req, coin_rej, chg_q, chg_d, chg_n, fault;
    logic [6:0] credit;
    logic [2:0] state;

    vend_sequencer #(.PRICE_UNITS(PR), .PULSE_CYCLES(P), .ACK_TIMEOUT(AT)) dut (
        .CLK50M     (CLK50M),
        .RSTb       (RSTb),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .cancel     (cancel),
        .disp_ack   (disp_ack),
        .disp_req   (disp_req),
        .coin_rej   (coin_rej),
        .chg_q      (chg_q),
        .chg_d      (chg_d),
        .chg_n      (chg_n),
        .credit     (credit),
        .state      (state),
        .fault      (fault)
    );

    always #10 CLK50M = ~CLK50M;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 collecting credit, 1 vending (m_vt cycles since request), 2 paying out
    // a precomputed greedy coin list along a fixed select/pulse/gap timeline.
    int coin_units[4] = '{1, 2, 5, 10};
    int m_mode = 0, m_c = 0, m_vt = 0, m_t = 0, m_pay0 = 0, m_n = 0;
    int m_coins[8];
    bit m_rej = 1'b0, m_fault = 1'b0;

    task automatic start_pay(input int amt);
        int x, u;
        x = amt;
        m_pay0 = amt;
        m_n = 0;
        m_t = 0;
        m_mode = 2;
        while (x > 0) begin
            u = (x >= 5) ? 5 : (x >= 2) ? 2 : 1;
            m_coins[m_n] = u;
            m_n++;
            x -= u;
        end
    endtask

    always @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            m_mode = 0; m_c = 0; m_vt = 0; m_t = 0;
            m_rej = 1'b0; m_fault = 1'b0;
        end else begin
            m_rej = coin_valid && (cancel || m_mode != 0);
            m_fault = 1'b0;
            case (m_mode)
                0: begin
                    if (cancel) begin
                        if (m_c > 0) start_pay(m_c);
                    end else if (coin_valid) begin
                        m_c += coin_units[coin_code];
                        if (m_c >= PR) begin
                            m_mode = 1;
                            m_vt = 0;
                        end
                    end
                end
                1: begin
                    if (m_vt >= 1 && disp_ack) begin
                        if (m_c - PR > 0) start_pay(m_c - PR);
                        else begin m_mode = 0; m_c = 0; end
                    end
`ifdef VEND_ACK_TIMEOUT_EN
                    else if (m_vt == AT - 1) begin
                        m_fault = 1'b1;
                        start_pay(m_c);
                    end
`endif
                    else m_vt++;
                end
                default: begin
                    m_t++;
                    if (m_t == m_n * PER) begin m_mode = 0; m_c = 0; end
                end
            endcase
        end
    end

    always @(negedge CLK50M) begin : cmp
        int e_state, e_credit, k, r;
        bit pulsing;
        if (RSTb) begin
            e_state = 0; e_credit = 0; k = 0; r = 0; pulsing = 1'b0;
            if (m_mode == 0) begin
                e_state = (m_c == 0) ? 0 : 1;
                e_credit = m_c;
            end else if (m_mode == 1) begin
                e_state = (m_vt == 0) ? 2 : 3;
                e_credit = m_c;
            end else begin
                k = m_t / PER;
                r = m_t % PER;
                e_credit = m_pay0;
                for (int i = 0; i < k; i++) e_credit -= m_coins[i];
                if (r > P) e_credit -= m_coins[k];
                e_state = (r == 0) ? 4 : (r <= P) ? 5 : 6;
                pulsing = (r >= 1) && (r <= P);
            end
            chk("state", int'(state), e_state);
            chk("credit", int'(credit), e_credit);
            chk("disp_req", int'(disp_req), int'(m_mode == 1));
            chk("coin_rej", int'(coin_rej), int'(m_rej));
            chk("fault", int'(fault), int'(m_fault));
            chk("chg_q", int'(chg_q), int'(pulsing && m_coins[k] == 5));
            chk("chg_d", int'(chg_d), int'(pulsing && m_coins[k] == 2));
            chk("chg_n", int'(chg_n), int'(pulsing && m_coins[k] == 1));
        end
    end

    task automatic step(input bit cv, input int cc, input bit cn, input bit ak);
        coin_valid = cv;
        coin_code  = 2'(cc);
        cancel     = cn;
        disp_ack   = ak;
        @(negedge CLK50M);
        #1;
    endtask

    task automatic run_to_idle(output int nq, output int nd, output int nn, output int nreq);
        nq = 0; nd = 0; nn = 0; nreq = 0;
        for (int i = 0; i < 400; i++) begin
            step(0, 0, 0, 0);
            nq += int'(chg_q);
            nd += int'(chg_d);
            nn += int'(chg_n);
            nreq += int'(disp_req);
            if (state == 3'd0) return;
        end
        chk("idle_reached", int'(state), 0);
    endtask

    initial begin
        int nq, nd, nn, nreq, seen;
        repeat (3) @(negedge CLK50M);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_disp_req", int'(disp_req), 0);
        chk("rst_chg", int'({chg_q, chg_d, chg_n}), 0);
        RSTb = 1'b1;
        step(0, 0, 0, 0);

        // quarter, ack three cycles later
        step(1, 2, 0, 0);
        chk("q_req", int'(disp_req), 1);
        chk("q_credit", int'(credit), 5);
        chk("q_state", int'(state), 2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("q_req_drop", int'(disp_req), 0);
        chk("q_final_credit", int'(credit), 0);
        chk("q_final_state", int'(state), 0);

        // half dollar gives one quarter back
        step(1, 3, 0, 0);
        chk("h_credit", int'(credit), 10);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("h_sel_state", int'(state), 4);
        chk("h_sel_credit", int'(credit), 5);
        run_to_idle(nq, nd, nn, nreq);
        chk("h_q_cycles", nq, 16);
        chk("h_dn_cycles", nd + nn, 0);
        chk("h_credit_end", int'(credit), 0);

        // three dimes
        step(1, 1, 0, 0);
        chk("d1_credit", int'(credit), 2);
        step(1, 1, 0, 0);
        chk("d2_credit", int'(credit), 4);
        step(1, 1, 0, 0);
        chk("d3_credit", int'(credit), 6);
        chk("d3_state", int'(state), 2);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("d_sel_credit", int'(credit), 1);
        run_to_idle(nq, nd, nn, nreq);
        chk("d_n_cycles", nn, 16);
        chk("d_qd_cycles", nq + nd, 0);

        // dime + nickel then cancel
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("c_credit", int'(credit), 3);
        step(0, 0, 1, 0);
        chk("c_state", int'(state), 4);
        run_to_idle(nq, nd, nn, nreq);
        chk("c_d_cycles", nd, 16);
        chk("c_n_cycles", nn, 16);
        chk("c_no_req", nreq, 0);

        // coin during VEND_WAIT, then coin with cancel
        step(1, 2, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("w_rej", int'(coin_rej), 1);
        chk("w_credit", int'(credit), 5);
        step(0, 0, 0, 0);
        chk("w_rej_clear", int'(coin_rej), 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 3, 1, 0);
        chk("cc_rej", int'(coin_rej), 1);
        chk("cc_state", int'(state), 4);
        chk("cc_credit", int'(credit), 1);
        run_to_idle(nq, nd, nn, nreq);
        chk("cc_n_cycles", nn, 16);

`ifdef VEND_ACK_TIMEOUT_EN
        step(1, 2, 0, 0);
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, 0);
            if (fault) begin seen = i; break; end
        end
        chk("to_cycle", seen, 8);
        chk("to_req", int'(disp_req), 0);
        chk("to_credit", int'(credit), 5);
        run_to_idle(nq, nd, nn, nreq);
        chk("to_q_cycles", nq, 16);
`endif

        // reset in the middle of a change pulse
        step(1, 3, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("r_pulse", int'(chg_q), 1);
        #5;
        RSTb = 1'b0;
        #1;
        chk("r_outputs", int'({disp_req, coin_rej, chg_q, chg_d, chg_n, fault}), 0);
        chk("r_credit", int'(credit), 0);
        chk("r_state", int'(state), 0);
        @(negedge CLK50M);
        #1;
        RSTb = 1'b1;
        step(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 30, int'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 30);
        run_to_idle(nq, nd, nn, nreq);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Transaction controller for the vending datapath.
- Accepts one-cycle coin strobes from the debounced coin front end and accumulates credit against a fixed price.
- When price is met, requests an item from the dispenser over a req/ack handshake, then pays out change as timed coin-release pulses.
- Sits between the coin encoder/debouncers and the item/change actuator outputs; exports state and credit for the display logic.

Parameters:
- PRICE_UNITS, 5, item price in 5-cent units (5 = 25c); legal 1..63.
- PULSE_CYCLES, 16, high time of each change pulse and gap after it, in CLK50M cycles; legal >= 1.
- ACK_TIMEOUT, 1024, cycles allowed between disp_req rise and disp_ack; used only with VEND_ACK_TIMEOUT_EN.

Ports:
- CLK50M  in  1  system clock
- RSTb  in  1  asynchronous active-low reset
- coin_valid  in  1  one-cycle strobe, coin present
- coin_code  in  2  0=nickel(1u) 1=dime(2u) 2=quarter(5u) 3=half(10u)
- cancel  in  1  one-cycle strobe, refund request
- disp_ack  in  1  dispenser done, level, sampled while waiting
- disp_req  out  1  item request, held until ack
- coin_rej  out  1  one-cycle pulse, coin not credited (return chute)
- chg_q / chg_d / chg_n  out  1 each  change release pulses (quarter/dime/nickel)
- credit  out  7  current credit in units
- state  out  3  encoded FSM state for LEDs
- fault  out  1  one-cycle pulse on dispense timeout

Behaviour:
- Reset (async, RSTb=0): state IDLE, credit 0, all outputs 0, timers 0. Reset mid-transaction drops credit; no refund.
- All outputs registered.
- States: IDLE, CREDIT, VEND_REQ, VEND_WAIT, CHG_SEL, CHG_PULSE, CHG_GAP.
- IDLE/CREDIT:
  - coin_valid adds the coin value to credit at the next edge.
  - If new credit >= PRICE_UNITS, go to VEND_REQ; disp_req is high the cycle after the accepting edge. Otherwise go to CREDIT.
- cancel in CREDIT: change = credit; go to CHG_SEL. cancel in IDLE: ignored.
- cancel and coin_valid in the same cycle: cancel wins; coin_rej pulses; credit unchanged before refund.
- coin_valid in any state other than IDLE/CREDIT: coin_rej pulses next cycle; credit unchanged. cancel is ignored in those states.
- VEND_REQ: disp_req=1; go to VEND_WAIT next cycle.
- VEND_WAIT: disp_req stays 1. On disp_ack=1:
  - disp_req drops next cycle; credit -= PRICE_UNITS.
  - Go to CHG_SEL if the remainder > 0, else IDLE.
- CHG_SEL: pick the largest of 5/2/1 units <= remaining credit (greedy); go to CHG_PULSE.
- CHG_PULSE: the selected chg_* output is high exactly PULSE_CYCLES cycles; credit decrements by the coin value at pulse end.
- CHG_GAP: all chg_* low for PULSE_CYCLES cycles. Then CHG_SEL if credit > 0, else IDLE.
- At most one chg_* is high at any time.
- Credit width rule: max credit = PRICE_UNITS-1+10 <= 72, fits 7 bits; no overflow/saturation path needed.
- disp_ack high outside VEND_WAIT: ignored.

Optional Feature:
- Macro VEND_ACK_TIMEOUT_EN.
- Defined: counter starts on VEND_REQ entry. If disp_ack is not seen after ACK_TIMEOUT cycles in VEND_WAIT:
  - disp_req drops and fault pulses one cycle.
  - Full credit (not reduced by price) is refunded via CHG_SEL.
- Undefined: no counter; VEND_WAIT waits indefinitely; fault tied 0.

Decomposition:
- Package vend_pkg holds:
  - state enum (3-bit, fixed encoding IDLE=0 .. CHG_GAP=6)
  - coin code enum
  - coin value constants NICKEL_U=1, DIME_U=2, QUARTER_U=5, HALF_U=10
  - a coin_value function mapping code to units
- Sub-module vend_pulse_timer:
  - Loadable down-counter with a done flag.
  - Shared for pulse/gap timing and, when enabled, ack timeout.

Test Plan:
- PRICE_UNITS=5: one quarter -> disp_req rises 1 cycle after accept; ack after 3 cycles -> disp_req falls; credit 0; no chg pulses; state IDLE.
- Half dollar (10u) -> vend; after ack, exactly one chg_q pulse of 16 cycles, 16-cycle gap, then IDLE with credit 0.
- Three dimes (6u) -> credit 2, 4, then 6 triggers vend; after ack one chg_n pulse; final credit 0.
- Dime + nickel, then cancel -> chg_d pulse then chg_n pulse, separated by 16 low cycles; no disp_req.
- Coin strobed during VEND_WAIT, and coin simultaneous with cancel -> coin_rej one-cycle pulse each time; credit unaffected.
- VEND_ACK_TIMEOUT_EN, ACK_TIMEOUT=8, quarter, no ack -> fault pulse at cycle 8, refund one chg_q. Separately: RSTb low during CHG_PULSE -> all outputs 0 immediately, credit 0.
